// File: rtl/mips_exec_pkg.sv
// Shared widths and ALU function codes for the MIPS execute-side units.
package mips_exec_pkg;

   localparam int unsigned DW   = 32;
   localparam int unsigned NREG = 32;

   typedef enum logic [2:0] {
      ALU_AND  = 3'b000,
      ALU_OR   = 3'b001,
      ALU_ADD  = 3'b010,
      ALU_RSVD = 3'b011,
      ALU_ANDN = 3'b100,
      ALU_ORN  = 3'b101,
      ALU_SUB  = 3'b110,
      ALU_SLT  = 3'b111
   } alu_op_e;

endpackage

// File: rtl/mips_regfile32.sv
// Register file: combinational reads, posedge write, r0 hard-wired to zero,
// async active-low clear. REGFILE_BYPASS_EN enables write-through bypass.
module mips_regfile32 #(
   parameter int unsigned DW   = mips_exec_pkg::DW,
   parameter int unsigned NREG = mips_exec_pkg::NREG,
   parameter int unsigned AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   input  logic [AW-1:0] wa,
   input  logic          we,
   input  logic [DW-1:0] wd,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2
);

   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];
   logic          wr_en;

   assign wr_en = we && (wa != '0);

   // Next-state array: copy current contents, overlay the WB write.
   always_comb begin
      regs_d = regs_q;
      if (wr_en) regs_d[wa] = wd;
   end

   // Storage with asynchronous clear; a write on a reset edge is lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read ports: r0 masked; optional same-cycle bypass of the WB write,
   // suppressed during reset so reads stay zero while reset_n is low.
   always_comb begin
      rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
      rd2 = (ra2 == '0) ? '0 : regs_q[ra2];
`ifdef REGFILE_BYPASS_EN
      if (reset_n && wr_en && (wa == ra1)) rd1 = wd;
      if (reset_n && wr_en && (wa == ra2)) rd2 = wd;
`endif
   end

endmodule

// File: rtl/mips_exec_units.sv
// Execute-side core: register file, 16->32 sign extender and ALU.
// REGFILE_BYPASS_EN (optional) enables register-file write-through bypass.
module mips_exec_units #(
   parameter int unsigned DW   = mips_exec_pkg::DW,
   parameter int unsigned NREG = mips_exec_pkg::NREG
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [$clog2(NREG)-1:0]  ra1,
   input  logic [$clog2(NREG)-1:0]  ra2,
   input  logic [$clog2(NREG)-1:0]  wa,
   input  logic                     we,
   input  logic [DW-1:0]            wd,
   output logic [DW-1:0]            rd1,
   output logic [DW-1:0]            rd2,
   input  logic [15:0]              imm_x,
   output logic [DW-1:0]            imm_y,
   input  logic [DW-1:0]            alu_a,
   input  logic [DW-1:0]            alu_b,
   input  logic [2:0]               alu_f,
   output logic [DW-1:0]            alu_y,
   output logic                     alu_zf
);

   import mips_exec_pkg::*;

   mips_regfile32 #(
      .DW   (DW),
      .NREG (NREG)
   ) u_regfile (
      .clk     (clk),
      .reset_n (reset_n),
      .ra1     (ra1),
      .ra2     (ra2),
      .wa      (wa),
      .we      (we),
      .wd      (wd),
      .rd1     (rd1),
      .rd2     (rd2)
   );

   assign imm_y = {{(DW-16){imm_x[15]}}, imm_x};

   logic slt;
   assign slt = $signed(alu_a) < $signed(alu_b);

   // ALU function decode; SLT uses a true signed compare, not the sign of A-B.
   always_comb begin
      alu_y = '0;
      case (alu_op_e'(alu_f))
         ALU_AND:  alu_y = alu_a & alu_b;
         ALU_OR:   alu_y = alu_a | alu_b;
         ALU_ADD:  alu_y = alu_a + alu_b;
         ALU_ANDN: alu_y = alu_a & ~alu_b;
         ALU_ORN:  alu_y = alu_a | ~alu_b;
         ALU_SUB:  alu_y = alu_a - alu_b;
         ALU_SLT:  alu_y = {{(DW-1){1'b0}}, slt};
         default:  alu_y = '0;
      endcase
   end

   assign alu_zf = (alu_y == '0);

endmodule

// File: tb/tb_mips_exec_units.sv
// Directed self-checking bench for mips_exec_units (with or without REGFILE_BYPASS_EN).
module tb_mips_exec_units;

   logic        clk;
   logic        reset_n;
   logic [4:0]  ra1, ra2, wa;
   logic        we;
   logic [31:0] wd, rd1, rd2;
   logic [15:0] imm_x;
   logic [31:0] imm_y, alu_a, alu_b, alu_y;
   logic [2:0]  alu_f;
   logic        alu_zf;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   mips_exec_units dut (
      .clk     (clk),
      .reset_n (reset_n),
      .ra1     (ra1),
      .ra2     (ra2),
      .wa      (wa),
      .we      (we),
      .wd      (wd),
      .rd1     (rd1),
      .rd2     (rd2),
      .imm_x   (imm_x),
      .imm_y   (imm_y),
      .alu_a   (alu_a),
      .alu_b   (alu_b),
      .alu_f   (alu_f),
      .alu_y   (alu_y),
      .alu_zf  (alu_zf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   typedef struct {
      string       tag;
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] y;
      logic        zf;
   } alu_vec_t;

   alu_vec_t alu_vecs[$] = '{
      '{"add_wrap0", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1},
      '{"sub_neg",   3'b110, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0},
      '{"add_ovf",   3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0},
      '{"and",       3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0},
      '{"or",        3'b001, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0},
      '{"andn",      3'b100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hF000_F000, 1'b0},
      '{"orn",       3'b101, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hF0FF_F0FF, 1'b0},
      '{"slt_ovf1",  3'b111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0},
      '{"slt_ovf0",  3'b111, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 1'b1},
      '{"slt_big",   3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b1},
      '{"reserved",  3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h0000_0000, 1'b1}
   };

   logic [31:0] same_cycle_exp;

   initial begin
      reset_n = 1'b0;
      ra1 = '0; ra2 = '0; wa = '0; we = 1'b0; wd = '0;
      imm_x = '0; alu_a = '0; alu_b = '0; alu_f = '0;

      // 1: reset state and writes ignored while in reset
      #3;
      ra1 = 5'd5; ra2 = 5'd31;
      #1;
      check("rst_rd1", rd1, 32'h0);
      check("rst_rd2", rd2, 32'h0);
      we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      check("rst_wr_held", rd1, 32'h0);
      we = 1'b0;
      @(posedge clk); #1;
      check("rst_wr_ignored", rd1, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("post_rst_rd1", rd1, 32'h0);

      // 2: register file writes
      @(negedge clk);
      we = 1'b1; wa = 5'd0; wd = 32'h0000_1234; ra1 = 5'd0;
      #1;
      check("r0_bypass", rd1, 32'h0);
      @(posedge clk); #1;
      check("r0_write", rd1, 32'h0);
      @(negedge clk);
      wa = 5'd7; wd = 32'hCAFE_F00D; ra2 = 5'd7;
      @(posedge clk); #1;
      we = 1'b0;
      check("r7_next", rd2, 32'hCAFE_F00D);
      @(negedge clk);
      we = 1'b1; wa = 5'd7; wd = 32'h1234_5678; ra1 = 5'd7;
      #1;
`ifdef REGFILE_BYPASS_EN
      same_cycle_exp = 32'h1234_5678;
`else
      same_cycle_exp = 32'hCAFE_F00D;
`endif
      check("r7_same_cycle", rd1, same_cycle_exp);
      @(posedge clk); #1;
      we = 1'b0;
      check("r7_after", rd1, 32'h1234_5678);
      ra2 = 5'd5;
      #1;
      check("r5_untouched", rd2, 32'h0);

      // 3: sign extender
      imm_x = 16'h7FFF; #1; check("sx_7fff", imm_y, 32'h0000_7FFF);
      imm_x = 16'h8000; #1; check("sx_8000", imm_y, 32'hFFFF_8000);
      imm_x = 16'hFFFF; #1; check("sx_ffff", imm_y, 32'hFFFF_FFFF);

      // 4/5: ALU vectors
      foreach (alu_vecs[i]) begin
         alu_f = alu_vecs[i].f;
         alu_a = alu_vecs[i].a;
         alu_b = alu_vecs[i].b;
         #1;
         check({alu_vecs[i].tag, "_y"}, alu_y, alu_vecs[i].y);
         check({alu_vecs[i].tag, "_zf"}, {31'b0, alu_zf}, {31'b0, alu_vecs[i].zf});
      end

      // 6: asynchronous reset between clock edges
      @(negedge clk);
      we = 1'b1; wa = 5'd3; wd = 32'h0000_0055; ra1 = 5'd3; ra2 = 5'd7;
      @(posedge clk); #1;
      we = 1'b0;
      #1;
      check("r3_loaded", rd1, 32'h0000_0055);
      #1;
      reset_n = 1'b0;
      #1;
      check("async_rst_r3", rd1, 32'h0);
      check("async_rst_r7", rd2, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("post_async_r3", rd1, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
